// File: rtl/snake_pkg.sv
// snake_pkg: shared definitions for the snake display pipeline.
// Contents: default length/index sizing, the game-area bounds, the body
// streamer FSM state encoding and the figure codes used by the renderer.
package snake_pkg;

    // Default sizing of the body table.
    localparam int SNAKE_LENGTH_BIT = 4;
    localparam int SNAKE_LENGTH_MAX = 16;

    // Width of one body-table coordinate.
    localparam int COORD_W = 7;

    // Game-area bounds in screen pixels.
    localparam int X_OFF = 58;
    localparam int Y_OFF = 43;
    localparam int X_FIN = 678;
    localparam int Y_FIN = 448;

    // Body streamer sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_READ    = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_RELEASE = 3'd4
    } stream_state_e;

    // Figure codes drawn by the graphic block.
    typedef enum logic [1:0] {
        FIG_HEAD  = 2'd0,
        FIG_BODY  = 2'd1,
        FIG_TAIL  = 2'd2,
        FIG_FRUIT = 2'd3
    } figure_e;

endpackage

// File: rtl/snake_body_streamer_if.sv
// snake_body_streamer_if: lock handshake and body-RAM read bus between the
// body streamer (master) and the movement logic / body RAM (slave).
//   lock_req  master->slave  request to freeze the body table
//   lock_ack  slave->master  freeze granted
//   rd_addr   master->slave  body RAM read address
//   rd_x/rd_y slave->master  read data, valid one cycle after rd_addr
interface snake_body_streamer_if #(
    parameter int SNAKE_LENGTH_BIT = snake_pkg::SNAKE_LENGTH_BIT
);
    import snake_pkg::*;

    logic                        lock_req;
    logic                        lock_ack;
    logic [SNAKE_LENGTH_BIT-1:0] rd_addr;
    logic [COORD_W-1:0]          rd_x;
    logic [COORD_W-1:0]          rd_y;

    modport master (
        output lock_req,
        output rd_addr,
        input  lock_ack,
        input  rd_x,
        input  rd_y
    );

    modport slave (
        input  lock_req,
        input  rd_addr,
        output lock_ack,
        output rd_x,
        output rd_y
    );

endinterface

// File: rtl/snake_body_streamer_frame_trigger_gen.sv
// frame_trigger_gen: decodes the screen counters into a single-cycle event
// on the first pixel of line TRIGGER_Y.
//   clk, rst_n  pixel clock, asynchronous active-low reset
//   x_i, y_i    horizontal / vertical screen counters
//   trigger_o   one-cycle pulse when x_i==0 && y_i==TRIGGER_Y
module frame_trigger_gen
    import snake_pkg::*;
#(
    parameter int PIXEL_DISPLAY_BIT = 9,
    parameter int TRIGGER_Y         = 460
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PIXEL_DISPLAY_BIT:0] x_i,
    input  logic [PIXEL_DISPLAY_BIT:0] y_i,
    output logic                     trigger_o
);

    localparam logic [PIXEL_DISPLAY_BIT:0] TRIG_Y = (PIXEL_DISPLAY_BIT+1)'(TRIGGER_Y);

    logic match;
    logic match_q;

    assign match = (x_i == '0) && (y_i == TRIG_Y);

    // Edge-detect so the event stays one cycle even if the counters stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match;
        end
    end

    assign trigger_o = match && !match_q;

endmodule

// File: rtl/snake_body_streamer.sv
// snake_body_streamer: once per frame, after the game area has been scanned,
// copies the body table from the game-logic body RAM into the graphic
// block's body registers under a four-phase lock handshake.
//   clock_25, reset      pixel clock, asynchronous active-low reset
//   X, Y                 screen counters (trigger decode)
//   snake_length         current number of segments, latched at trigger
//   mem                  lock handshake + body RAM read bus (master side)
//   body_count           table index written to the graphic block
//   snake_body_x/_y      entry data written to the graphic block
//   frame_done           one-cycle pulse when a copy completes
//   busy                 sequencer not idle
//   overrun              sticky, a trigger arrived while busy
//   stale_frame          (STREAM_TIMEOUT_EN only) sticky, lock wait timed out
// Optional feature macro: STREAM_TIMEOUT_EN.
module snake_body_streamer #(
    parameter int PIXEL_DISPLAY_BIT = 9,
    parameter int SNAKE_LENGTH_BIT  = snake_pkg::SNAKE_LENGTH_BIT,
    parameter int SNAKE_LENGTH_MAX  = snake_pkg::SNAKE_LENGTH_MAX,
    parameter int TRIGGER_Y         = 460
`ifdef STREAM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES    = 1024
`endif
) (
    input  logic                        clock_25,
    input  logic                        reset,
    input  logic [PIXEL_DISPLAY_BIT:0]  X,
    input  logic [PIXEL_DISPLAY_BIT:0]  Y,
    input  logic [SNAKE_LENGTH_BIT-1:0] snake_length,
    snake_body_streamer_if.master       mem,
    output logic [SNAKE_LENGTH_BIT-1:0] body_count,
    output logic [6:0]                  snake_body_x,
    output logic [6:0]                  snake_body_y,
    output logic                        frame_done,
    output logic                        busy,
    output logic                        overrun
`ifdef STREAM_TIMEOUT_EN
    ,
    output logic                        stale_frame
`endif
);
    import snake_pkg::*;

    localparam logic [SNAKE_LENGTH_BIT:0] LEN_MAX_W = (SNAKE_LENGTH_BIT+1)'(SNAKE_LENGTH_MAX);

    logic trigger;

    frame_trigger_gen #(
        .PIXEL_DISPLAY_BIT (PIXEL_DISPLAY_BIT),
        .TRIGGER_Y         (TRIGGER_Y)
    ) u_trigger (
        .clk       (clock_25),
        .rst_n     (reset),
        .x_i       (X),
        .y_i       (Y),
        .trigger_o (trigger)
    );

    stream_state_e               state_q, state_d;
    logic [SNAKE_LENGTH_BIT-1:0] len_q, len_d;
    logic [SNAKE_LENGTH_BIT-1:0] rd_addr_q, rd_addr_d;
    logic [SNAKE_LENGTH_BIT-1:0] pipe_addr_q, pipe_addr_d;
    logic                        pipe_v_q, pipe_v_d;
    logic                        lock_req_q, lock_req_d;
    logic [SNAKE_LENGTH_BIT-1:0] body_count_q, body_count_d;
    logic [COORD_W-1:0]          body_x_q, body_x_d;
    logic [COORD_W-1:0]          body_y_q, body_y_d;
    logic                        frame_done_q, frame_done_d;
    logic                        overrun_q, overrun_d;
    logic [SNAKE_LENGTH_BIT-1:0] len_clamped;

`ifdef STREAM_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             stale_q, stale_d;
`endif

    // Lengths above the table size are clamped to the table size.
    assign len_clamped = ({1'b0, snake_length} > LEN_MAX_W) ?
                         LEN_MAX_W[SNAKE_LENGTH_BIT-1:0] : snake_length;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        rd_addr_d    = rd_addr_q;
        pipe_addr_d  = pipe_addr_q;
        pipe_v_d     = 1'b0;
        lock_req_d   = lock_req_q;
        body_count_d = body_count_q;
        body_x_d     = body_x_q;
        body_y_d     = body_y_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q | (trigger && (state_q != ST_IDLE));
`ifdef STREAM_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        stale_d      = stale_q;
`endif

        // Graphic outputs only move when a read-pipeline entry is valid.
        if (pipe_v_q) begin
            body_count_d = pipe_addr_q;
            body_x_d     = mem.rd_x;
            body_y_d     = mem.rd_y;
        end

        unique case (state_q)
            ST_IDLE: begin
                lock_req_d = 1'b0;
                if (trigger) begin
                    len_d   = len_clamped;
                    state_d = ST_REQ;
`ifdef STREAM_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end

            ST_REQ: begin
                lock_req_d = 1'b1;
                if (mem.lock_ack) begin
                    if (len_q == '0) begin
                        state_d = ST_RELEASE;
                    end else begin
                        state_d   = ST_READ;
                        rd_addr_d = '0;
                    end
                end
`ifdef STREAM_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    lock_req_d = 1'b0;
                    stale_d    = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end

            ST_READ: begin
                // lock_ack is not re-checked here: a drop is a protocol
                // violation and the copy is allowed to complete.
                lock_req_d  = 1'b1;
                pipe_addr_d = rd_addr_q;
                pipe_v_d    = 1'b1;
                if (rd_addr_q == len_q - 1'b1) begin
                    state_d = ST_FLUSH;
                end else begin
                    rd_addr_d = rd_addr_q + 1'b1;
                end
            end

            ST_FLUSH: begin
                // Last entry leaves the pipeline on this edge.
                lock_req_d = 1'b1;
                state_d    = ST_RELEASE;
            end

            ST_RELEASE: begin
                lock_req_d = 1'b0;
                // Wait until lock_req is actually low so frame_done never
                // coincides with the request still being asserted.
                if (!lock_req_q && !mem.lock_ack) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
`ifdef STREAM_TIMEOUT_EN
                    stale_d      = 1'b0;
`endif
                end
            end

            default: begin
                lock_req_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            rd_addr_q    <= '0;
            pipe_addr_q  <= '0;
            pipe_v_q     <= 1'b0;
            lock_req_q   <= 1'b0;
            body_count_q <= '0;
            body_x_q     <= '0;
            body_y_q     <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef STREAM_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            stale_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            rd_addr_q    <= rd_addr_d;
            pipe_addr_q  <= pipe_addr_d;
            pipe_v_q     <= pipe_v_d;
            lock_req_q   <= lock_req_d;
            body_count_q <= body_count_d;
            body_x_q     <= body_x_d;
            body_y_q     <= body_y_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
`ifdef STREAM_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            stale_q      <= stale_d;
`endif
        end
    end

    assign mem.lock_req = lock_req_q;
    assign mem.rd_addr  = rd_addr_q;
    assign body_count   = body_count_q;
    assign snake_body_x = body_x_q;
    assign snake_body_y = body_y_q;
    assign frame_done   = frame_done_q;
    assign busy         = (state_q != ST_IDLE);
    assign overrun      = overrun_q;
`ifdef STREAM_TIMEOUT_EN
    assign stale_frame  = stale_q;
`endif

endmodule

// File: tb/tb_snake_body_streamer.sv
// Directed self-checking bench for snake_body_streamer (5-bit length build,
// 16-entry table, trigger line 460, lock timeout 8 when enabled).
module tb_snake_body_streamer;

    localparam int LB = 5;

    logic          clk;
    logic          rst_n;
    logic [9:0]    x_cnt;
    logic [9:0]    y_cnt;
    logic [LB-1:0] snake_length;
    logic [LB-1:0] body_count;
    logic [6:0]    body_x;
    logic [6:0]    body_y;
    logic          frame_done;
    logic          busy;
    logic          overrun;
`ifdef STREAM_TIMEOUT_EN
    logic          stale_frame;
`endif

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;

    logic [6:0] ram_x [32];
    logic [6:0] ram_y [32];

    snake_body_streamer_if #(.SNAKE_LENGTH_BIT(LB)) mem_if ();

    snake_body_streamer #(
        .PIXEL_DISPLAY_BIT (9),
        .SNAKE_LENGTH_BIT  (LB),
        .SNAKE_LENGTH_MAX  (16),
        .TRIGGER_Y         (460)
`ifdef STREAM_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES    (8)
`endif
    ) dut (
        .clock_25     (clk),
        .reset        (rst_n),
        .X            (x_cnt),
        .Y            (y_cnt),
        .snake_length (snake_length),
        .mem          (mem_if),
        .body_count   (body_count),
        .snake_body_x (body_x),
        .snake_body_y (body_y),
        .frame_done   (frame_done),
        .busy         (busy),
        .overrun      (overrun)
`ifdef STREAM_TIMEOUT_EN
        ,
        .stale_frame  (stale_frame)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous body RAM: data valid one cycle after the address.
    always @(posedge clk) begin
        mem_if.rd_x <= ram_x[mem_if.rd_addr];
        mem_if.rd_y <= ram_y[mem_if.rd_addr];
    end

    always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic trigger();
        x_cnt = 10'd0;
        y_cnt = 10'd460;
        @(negedge clk);
        x_cnt = 10'd1;
        y_cnt = 10'd0;
    endtask

    task automatic wait_lock(input logic lvl, input string tag);
        int n = 0;
        while (mem_if.lock_req !== lvl && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, mem_if.lock_req, lvl);
    endtask

    // Starts with lock_req high; grants the lock and checks the copy.
    task automatic copy_phase(input int n_exp, input string tag);
        logic [31:0] pb, px, py;
        int fd0;
        pb = body_count;
        px = body_x;
        py = body_y;
        mem_if.lock_ack = 1'b1;
        @(negedge clk);
        check({tag, "_noearly0"}, body_count, pb);
        if (n_exp == 0) begin
            @(negedge clk);
            check({tag, "_zero_cnt"}, body_count, pb);
            check({tag, "_zero_x"}, body_x, px);
            check({tag, "_zero_y"}, body_y, py);
        end else begin
            @(negedge clk);
            check({tag, "_noearly1"}, body_count, pb);
            for (int i = 0; i < n_exp; i++) begin
                @(negedge clk);
                check({tag, "_cnt"}, body_count, i);
                check({tag, "_x"}, body_x, ram_x[i]);
                check({tag, "_y"}, body_y, ram_y[i]);
            end
            @(negedge clk);
            check({tag, "_hold_cnt"}, body_count, n_exp - 1);
            check({tag, "_rd_addr"}, mem_if.rd_addr, n_exp - 1);
        end
        check({tag, "_req_low"}, mem_if.lock_req, 1'b0);
        check({tag, "_done_early"}, frame_done, 1'b0);
        mem_if.lock_ack = 1'b0;
        fd0 = fd_cnt;
        @(negedge clk);
        check({tag, "_done"}, frame_done, 1'b1);
        check({tag, "_idle"}, busy, 1'b0);
        @(negedge clk);
        check({tag, "_done_pulse"}, frame_done, 1'b0);
        check({tag, "_done_once"}, fd_cnt - fd0, 1);
    endtask

    task automatic do_frame(input int len, input int n_exp, input int ack_delay, input string tag);
        snake_length = LB'(len);
        trigger();
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_req_wait"}, mem_if.lock_req, 1'b0);
        wait_lock(1'b1, {tag, "_req_high"});
        repeat (ack_delay) @(negedge clk);
        copy_phase(n_exp, tag);
    endtask

    initial begin
        rst_n           = 1'b0;
        x_cnt           = 10'd1;
        y_cnt           = 10'd0;
        snake_length    = '0;
        mem_if.lock_ack = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ram_x[i] = (i < 16) ? 7'(10 + i) : 7'd99;
            ram_y[i] = (i < 16) ? 7'd20 : 7'd99;
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cnt", body_count, 0);
        check("rst_x", body_x, 0);
        check("rst_y", body_y, 0);
        check("rst_done", frame_done, 0);
        check("rst_busy", busy, 0);
        check("rst_ovr", overrun, 0);
        check("rst_req", mem_if.lock_req, 0);
        check("rst_addr", mem_if.rd_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // lock_ack high in IDLE is ignored
        mem_if.lock_ack = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ack_busy", busy, 0);
        check("idle_ack_req", mem_if.lock_req, 0);
        mem_if.lock_ack = 1'b0;
        @(negedge clk);

        do_frame(5, 5, 3, "basic");
        do_frame(0, 0, 1, "zero");
        do_frame(16, 16, 2, "full");
        do_frame(20, 16, 1, "clamp");

        // Overrun: second trigger while stuck in REQ, no re-latch of length
        snake_length = 5'd3;
        trigger();
        wait_lock(1'b1, "ovr_req_high");
        repeat (4) @(negedge clk);
        check("ovr_still_req", mem_if.lock_req, 1'b1);
        check("ovr_busy", busy, 1'b1);
        check("ovr_before", overrun, 1'b0);
        check("ovr_no_out", body_count, 15);
        snake_length = 5'd5;
        trigger();
        check("ovr_set", overrun, 1'b1);
        check("ovr_req_kept", mem_if.lock_req, 1'b1);
        copy_phase(3, "ovr");
        check("ovr_sticky", overrun, 1'b1);

        // Reset mid-READ after entry 2
        snake_length = 5'd5;
        trigger();
        wait_lock(1'b1, "rmid_req_high");
        mem_if.lock_ack = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rmid_cnt", body_count, i);
            check("rmid_x", body_x, ram_x[i]);
        end
        rst_n = 1'b0;
        #1;
        check("rmid_cnt0", body_count, 0);
        check("rmid_x0", body_x, 0);
        check("rmid_y0", body_y, 0);
        check("rmid_req0", mem_if.lock_req, 0);
        check("rmid_busy0", busy, 0);
        check("rmid_ovr0", overrun, 0);
        mem_if.lock_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_frame(5, 5, 2, "after_rst");

`ifdef STREAM_TIMEOUT_EN
        begin
            int fd0;
            fd0 = fd_cnt;
            snake_length = 5'd4;
            trigger();
            for (int i = 0; i < 7; i++) begin
                @(negedge clk);
                check("tmo_req_high", mem_if.lock_req, 1'b1);
            end
            @(negedge clk);
            check("tmo_req_low", mem_if.lock_req, 1'b0);
            check("tmo_stale", stale_frame, 1'b1);
            check("tmo_idle", busy, 1'b0);
            repeat (2) @(negedge clk);
            check("tmo_no_done", fd_cnt - fd0, 0);
            do_frame(2, 2, 0, "tmo_good");
            check("tmo_stale_clr", stale_frame, 1'b0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_body_streamer.md
Name: snake_body_streamer

Overview:
- Per-frame sequencer that copies the snake body table from the game-logic body RAM into the graphic block's local body registers.
- Each entry is sent as body_count / snake_body_x / snake_body_y.
- Runs once per frame, after the game area has been scanned (Y > 448), so the graphic block never renders a partly updated snake.
- Uses a four-phase lock handshake with the movement logic so the body table is frozen while it is copied.

Parameters:
- PIXEL_DISPLAY_BIT, 9, MSB index of the X/Y screen counters (counters are PIXEL_DISPLAY_BIT+1 bits wide).
- SNAKE_LENGTH_BIT, 4, width of length and index signals.
- SNAKE_LENGTH_MAX, 16, number of body table entries.
- TRIGGER_Y, 460, screen line on which the copy starts (must be greater than 448).
- TIMEOUT_CYCLES, 1024, lock-wait limit; used only with STREAM_TIMEOUT_EN.

Ports:
- clock_25  in  1  25 MHz pixel clock.
- reset  in  1  asynchronous, active-low reset.
- X  in  PIXEL_DISPLAY_BIT+1  horizontal screen counter (0..799).
- Y  in  PIXEL_DISPLAY_BIT+1  vertical screen counter.
- snake_length  in  SNAKE_LENGTH_BIT  current number of segments.
- lock_req  out  1  request to freeze the body table.
- lock_ack  in  1  movement logic grants the freeze.
- rd_addr  out  SNAKE_LENGTH_BIT  body RAM read address.
- rd_x, rd_y  in  7 each  body RAM read data; valid 1 cycle after rd_addr.
- body_count  out  SNAKE_LENGTH_BIT  table index to the graphic block.
- snake_body_x, snake_body_y  out  7 each  entry data to the graphic block.
- frame_done  out  1  one-cycle pulse when a copy completes.
- busy  out  1  high from trigger until the return to IDLE.
- overrun  out  1  sticky; a trigger arrived while busy.

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE. len_q and internal counters are 0.
- Trigger: one-cycle event when X==0 && Y==TRIGGER_Y.
  - In IDLE: latch len_q = min(snake_length, SNAKE_LENGTH_MAX), go to REQ.
  - Not in IDLE: ignored, overrun<=1. overrun clears only on reset.
- FSM states: IDLE, REQ, READ, FLUSH, RELEASE.
- REQ:
  - lock_req<=1.
  - When lock_ack==1 is sampled: if len_q==0 go to RELEASE, otherwise go to READ with rd_addr<=0.
- READ:
  - rd_addr increments by 1 each cycle.
  - Pipeline: addr_d<=rd_addr and a valid bit v_d.
  - Each cycle with v_d==1: body_count<=addr_d, snake_body_x<=rd_x, snake_body_y<=rd_y.
  - When rd_addr==len_q-1, go to FLUSH.
- FLUSH: the last entry is written to the outputs, then go to RELEASE.
- RELEASE:
  - lock_req<=0.
  - Wait for lock_ack==0, then pulse frame_done for 1 cycle and return to IDLE.
- Latency: from lock_ack sampled high, the first entry appears on the outputs 2 cycles later. Last entry at lock_ack+len_q+1. lock_req falls the following cycle.
- Hold rule:
  - Outside an active transfer, body_count, snake_body_x and snake_body_y hold their last values. The graphic block writes every cycle, so holding rewrites the same value and is harmless.
  - Outputs never change while v_d==0.
- rd_addr holds its last value when not in READ.
- busy = (state != IDLE).
- lock_ack high while in IDLE: ignored.
- lock_ack dropping during READ: protocol violation; the copy still completes (no abort).
- snake_length changes after the trigger: ignored until the next frame.
- Reset asserted mid-transfer: immediate return to IDLE with lock_req=0. The graphic registers keep partial data until the next frame.

Optional Feature:
- Macro: STREAM_TIMEOUT_EN.
- Defined:
  - A counter runs in REQ.
  - If lock_ack is not seen within TIMEOUT_CYCLES cycles, drop lock_req, go to IDLE with no frame_done, and assert sticky output stale_frame (1 bit, cleared on reset or on the next successful frame_done).
- Not defined: REQ waits indefinitely; the stale_frame port and the counter do not exist.

Decomposition:
- Shared package snake_pkg:
  - SNAKE_LENGTH_BIT, SNAKE_LENGTH_MAX.
  - Game-area bounds: X_off=58, Y_off=43, X_fin=678, Y_fin=448.
  - State encoding localparams (IDLE..RELEASE, 3 bits).
  - HEAD/BODY/TAIL/FRUIT figure codes.
- Natural sub-module: frame_trigger_gen. It decodes X/Y into the single-cycle trigger, so the same decode can later drive fruit and score refresh.
- FSM and read pipeline stay in this module.

Test Plan:
- Basic copy: snake_length=5, RAM x=10..14, y=20. Trigger, lock_ack 3 cycles after lock_req → body_count 0..4 on consecutive cycles, x 10..14, frame_done exactly once, lock_req low before frame_done.
- Zero length: snake_length=0 → lock handshake completes, no output change, frame_done pulses.
- Full and clamped length: snake_length=16 → 16 entries, last body_count=15, rd_addr stops at 15. With a 5-bit length variant driving 20, exactly 16 entries are sent.
- Overrun: hold lock_ack=0 across two triggers → overrun=1, state stays REQ, no second latch.
- Reset mid-READ after entry 2 → all outputs 0 and lock_req=0 at once. The next frame's copy runs normally.
- STREAM_TIMEOUT_EN with TIMEOUT_CYCLES=8 and lock_ack stuck 0 → lock_req drops after 8 cycles, stale_frame=1, no frame_done. The next good frame clears stale_frame.
